// File: rtl/debounce_edge.sv
// Two-flop synchronizer plus stability-counter debouncer for a raw asynchronous level.
// Produces a clean registered level q and single-cycle rise/fall pulses on acceptance.
module debounce_edge #(
  parameter int unsigned DEBOUNCE = 50000,
  parameter int unsigned CNT_W    = 16,
  parameter logic        RST_VAL  = 1'b0
) (
  input  logic clk,
  input  logic r,
  input  logic en,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  // Count value at which a sustained difference is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             q_q, q_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: counter clears on disable, on match and on acceptance; it never wraps.
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    q_d     = q_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (en && (sync2_q != q_q)) begin
      if (cnt_q == CNT_LAST) begin
        q_d    = sync2_q;
        rise_d = sync2_q;
        fall_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Reset forces q without producing a pulse.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      q_q     <= RST_VAL;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: doc/debounce_edge.md
Name: debounce_edge

Overview:
- Input conditioner that sits directly upstream of the team's async reset/set D flip-flop.
- Takes a raw asynchronous level (push-button, external strap, slow control pin) and synchronizes it into the clk domain.
- Filters bounces/glitches shorter than a programmable number of cycles.
- Outputs a clean level q plus one-cycle rise/fall pulses, suitable to drive a flip-flop's d or clock-enable logic.

Parameters:
- DEBOUNCE, 50000, number of consecutive clk cycles the synchronized input must differ from q before q updates; legal range 1 .. 2**CNT_W.
- CNT_W, 16, width of the stability counter; must hold DEBOUNCE-1.
- RST_VAL, 0, value loaded into sync stages and q on reset (0 or 1).

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- r  input  1  asynchronous active-low reset, asserted independent of clk.
- en  input  1  filter enable; synchronous, active-high.
- din  input  1  raw asynchronous input level.
- q  output  1  debounced, registered level.
- rise  output  1  one-cycle pulse, registered, high in the cycle q goes 0->1.
- fall  output  1  one-cycle pulse, registered, high in the cycle q goes 1->0.

Behaviour:
- Reset (r low, asynchronous):
  - sync1, sync2, q <= RST_VAL.
  - cnt <= 0; rise, fall <= 0.
  - Holds while r low. Deassertion takes effect on the first clk edge after r high.
- Synchronizer:
  - Two-stage: sync1 <= din, sync2 <= sync1 every edge, regardless of en.
  - No other logic reads din or sync1.
- Stability counter, evaluated per rising edge with priority top-down:
  1. en == 0: cnt <= 0; q holds; rise = fall = 0.
  2. sync2 == q: cnt <= 0 (any difference run is aborted).
  3. sync2 != q and cnt == DEBOUNCE-1: q <= sync2; cnt <= 0; rise <= sync2; fall <= ~sync2.
  4. sync2 != q otherwise: cnt <= cnt + 1.
- Pulses: rise and fall default to 0 every edge unless rule 3 fires. They are never high simultaneously and never high for 2 consecutive cycles.
- Latency: let edge 1 be the first edge sampling the new din level with din held thereafter. q (and rise or fall) change at edge DEBOUNCE+2.
- Glitch rejection:
  - A din level held for DEBOUNCE-1 or fewer sampling edges never changes q.
  - A level held for exactly DEBOUNCE sampling edges is accepted.
- Boundary cases:
  - DEBOUNCE=1: q follows sync2 one edge later, i.e. latency 3 edges.
  - Counter never wraps; it is cleared on acceptance, on match, and when en == 0.
  - en dropped mid-count discards progress; counting restarts from 0 when en returns.
  - din toggling during a run back to q's value clears cnt; the next difference starts from 0.
  - Reset mid-count or mid-pulse: all state returns to reset values immediately. rise/fall are not generated by the reset itself, even if q changes value.
  - No state machine beyond q and cnt; no combinational path from din to any output.

Test Plan (sim with DEBOUNCE=4, CNT_W=3, RST_VAL=0, en=1 unless stated):
- Reset: r=0 with din=1 for 5 cycles -> q=0, rise=0, fall=0 throughout. Release r with din=1 -> q=1 and rise=1 at edge 6 after release, rise=0 at edge 7.
- Clean edges: din 0->1 held -> q=1 exactly at edge 6 with a single-cycle rise. Then din 1->0 held -> q=0 at edge 6 with a single-cycle fall; rise stays 0.
- Glitch: din=1 for exactly 3 sampled cycles, then 0 -> q stays 0, no pulses. din=1 for exactly 4 cycles -> q=1 for 4 cycles, with rise then fall pulses.
- Bounce: din pattern 1,0,1,1,0,1 then steady 1 -> q rises only after 4 consecutive 1s reach sync2. Exactly one rise pulse.
- Enable: start counting a 0->1, drop en for 2 cycles at cnt=2, restore en -> q changes 4 cycles after en returns; no pulse while en=0.
- Async reset mid-operation: assert r between clk edges while cnt=3 and q=0, din=1 -> cnt, q, rise clear immediately without a clk edge. After release, a full 6-edge latency applies.
